apb_req_arbiter: RTL and testbench



---
 rtl/bridge_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/apb_req_arbiter.sv | 177 +++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and helpers for the AHB2APB bridge blocks.
package bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP,
        ERR_RESP
    } apb_arb_state_t;

    localparam int TIMEOUT_DEF = 16;

    // Width of the slave-index address field; never narrower than one bit
    function automatic int slv_idx_w(input int slaves);
        return (slaves > 1) ? $clog2(slaves) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic            any
);

    int j;

    // Scan NREQ slots starting at ptr; the first requester found wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = PW'(j);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master port among NREQ requesters, one transfer at a time.
// All outputs are registered; the FSM computes next values combinationally.
module apb_req_arbiter
    import bridge_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int WIDTH     = 32,
    parameter int SLAVES    = 4,
    parameter int SLV_SHIFT = 12,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_write,
    input  logic [NREQ-1:0][31:0]      req_addr,
    input  logic [NREQ-1:0][WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            done,
    output logic [WIDTH-1:0]           rsp_rdata,
    output logic                       rsp_err,
    output logic [31:0]                PADDR,
    output logic [WIDTH-1:0]           PWDATA,
    output logic                       PWRITE,
    output logic [SLAVES-1:0]          PSEL,
    output logic                       PENABLE,
    input  logic [WIDTH-1:0]           PRDATA,
    input  logic                       PREADY,
    input  logic                       PSLVERR,
    output logic                       busy
);

    localparam int IW = slv_idx_w(SLAVES);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    apb_arb_state_t state, state_n;
    logic [PW-1:0]  rr_ptr, rr_n;
    logic [PW-1:0]  gidx, gidx_n;
    logic [CW-1:0]  tcnt, tcnt_n;

    logic [NREQ-1:0]   gnt_n, done_n;
    logic [WIDTH-1:0]  rdata_n, pwdata_n;
    logic              err_n, pwrite_n, penable_n, busy_n;
    logic [31:0]       paddr_n;
    logic [SLAVES-1:0] psel_n;

    logic [NREQ-1:0]  arb_gnt;
    logic [PW-1:0]    arb_idx;
    logic             arb_any;
    logic [31:0]      sel_addr;
    logic [IW-1:0]    sel_slv;
    logic             sel_miss;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Address decode of the winning requester: slave index plus miss detection
    always_comb begin
        sel_addr = req_addr[arb_idx];
        sel_slv  = sel_addr[SLV_SHIFT +: IW];
        sel_miss = ((sel_addr >> (SLV_SHIFT + IW)) != 32'd0) ||
                   (int'(sel_slv) >= SLAVES);
    end

    // Next-state and next-output logic; registers hold unless a state acts
    always_comb begin
        state_n   = state;
        rr_n      = rr_ptr;
        gidx_n    = gidx;
        tcnt_n    = tcnt;
        gnt_n     = gnt;
        done_n    = '0;
        rdata_n   = rsp_rdata;
        err_n     = rsp_err;
        paddr_n   = PADDR;
        pwdata_n  = PWDATA;
        pwrite_n  = PWRITE;
        psel_n    = PSEL;
        penable_n = PENABLE;
        unique case (state)
            IDLE: begin
                if (arb_any) begin
                    gnt_n    = arb_gnt;
                    gidx_n   = arb_idx;
                    paddr_n  = sel_addr;
                    pwdata_n = req_wdata[arb_idx];
                    pwrite_n = req_write[arb_idx];
                    if (sel_miss) begin
                        // No APB access: complete straight away with an error
                        done_n  = arb_gnt;
                        err_n   = 1'b1;
                        rdata_n = '0;
                        state_n = ERR_RESP;
                    end else begin
                        psel_n  = SLAVES'(1) << sel_slv;
                        state_n = SETUP;
                    end
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                state_n   = ACCESS;
            end
            ACCESS: begin
                // PREADY is checked first so it beats a coincident timeout
                if (PREADY) begin
                    psel_n    = '0;
                    penable_n = 1'b0;
                    rdata_n   = PWRITE ? '0 : PRDATA;
                    err_n     = PSLVERR;
                    done_n    = gnt;
                    state_n   = RESP;
                end else if (tcnt == CW'(TIMEOUT - 1)) begin
                    psel_n    = '0;
                    penable_n = 1'b0;
                    rdata_n   = '0;
                    err_n     = 1'b1;
                    done_n    = gnt;
                    state_n   = ERR_RESP;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            RESP, ERR_RESP: begin
                gnt_n   = '0;
                tcnt_n  = '0;
                err_n   = 1'b0;
                rr_n    = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gidx      <= '0;
            tcnt      <= '0;
            gnt       <= '0;
            done      <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_n;
            gidx      <= gidx_n;
            tcnt      <= tcnt_n;
            gnt       <= gnt_n;
            done      <= done_n;
            rsp_rdata <= rdata_n;
            rsp_err   <= err_n;
            PADDR     <= paddr_n;
            PWDATA    <= pwdata_n;
            PWRITE    <= pwrite_n;
            PSEL      <= psel_n;
            PENABLE   <= penable_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Randomized bench for apb_req_arbiter against a transaction-level model.
module tb_apb_req_arbiter;

    localparam int NREQ = 2, WIDTH = 32, SLAVES = 4, SLV_SHIFT = 12, TIMEOUT = 16;

    logic                       HCLK = 1'b0;
    logic                       HRESETn;
    logic [NREQ-1:0]            req;
    logic [NREQ-1:0]            req_write;
    logic [NREQ-1:0][31:0]      req_addr;
    logic [NREQ-1:0][WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]            gnt, done;
    logic [WIDTH-1:0]           rsp_rdata;
    logic                       rsp_err;
    logic [31:0]                PADDR;
    logic [WIDTH-1:0]           PWDATA;
    logic                       PWRITE;
    logic [SLAVES-1:0]          PSEL;
    logic                       PENABLE;
    logic [WIDTH-1:0]           PRDATA;
    logic                       PREADY, PSLVERR;
    logic                       busy;

    apb_req_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SLAVES(SLAVES),
                      .SLV_SHIFT(SLV_SHIFT), .TIMEOUT(TIMEOUT)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .busy(busy)
    );

    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;

    // Requester-side model state
    bit          act    [NREQ];
    logic [31:0] a_addr [NREQ];
    logic [31:0] a_wdata[NREQ];
    bit          a_write[NREQ];
    int          a_wait [NREQ];
    logic [31:0] a_rdata[NREQ];
    bit          a_err  [NREQ];
    int          ptr = 0;

    // Slave behaviour for the transfer in flight
    int          s_wait  = 0;
    logic [31:0] s_rdata = '0;
    bit          s_err   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req[i]       = act[i];
            req_write[i] = a_write[i];
            req_addr[i]  = a_addr[i];
            req_wdata[i] = a_wdata[i];
        end
    endtask

    task automatic set_req(input int i, input bit on, input logic [31:0] addr, input bit wr,
                           input logic [31:0] wd, input int wt, input logic [31:0] rd,
                           input bit er);
        act[i] = on; a_addr[i] = addr; a_write[i] = wr; a_wdata[i] = wd;
        a_wait[i] = wt; a_rdata[i] = rd; a_err[i] = er;
    endtask

    task automatic new_txn(input int i);
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) a_addr[i] = $urandom | (32'h1 << $urandom_range(14, 31));
        else        a_addr[i] = $urandom_range(0, 32'h3FFF);
        a_write[i] = 1'($urandom_range(0, 1));
        a_wdata[i] = $urandom;
        a_rdata[i] = $urandom;
        a_err[i]   = ($urandom_range(0, 3) == 0);
        r = $urandom_range(0, 11);
        if (r == 0)      a_wait[i] = 100;
        else if (r == 1) a_wait[i] = TIMEOUT - 1;
        else             a_wait[i] = $urandom_range(0, 3);
    endtask

    task automatic refill();
        for (int j = 0; j < NREQ; j++)
            if (!act[j] && $urandom_range(0, 1) == 1) begin
                act[j] = 1'b1;
                new_txn(j);
            end
    endtask

    // APB slave: ready after s_wait access cycles, garbage data otherwise
    initial begin
        int acc;
        acc = 0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        forever begin
            @(negedge HCLK);
            if (PSEL != '0 && PENABLE) begin
                PREADY = (acc >= s_wait);
                PRDATA  = PREADY ? s_rdata : $urandom;
                PSLVERR = PREADY ? s_err : 1'($urandom_range(0, 1));
                acc++;
            end else begin
                PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'b0; acc = 0;
            end
        end
    end

    // One arbitration round starting in an IDLE cycle (called just after a posedge)
    task automatic serve(input bit rnd);
        int w, idx, nacc;
        bit miss, tmo;
        logic [NREQ-1:0]   ew;
        logic [SLAVES-1:0] esel;
        w = -1;
        for (int k = 0; k < NREQ; k++)
            if (w < 0 && act[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
        if (w < 0) begin
            @(negedge HCLK);
            chk("idle_quiet", {busy, gnt, PSEL, done}, '0);
            @(posedge HCLK); #1;
            if (rnd) begin refill(); drive_reqs(); end
            return;
        end
        s_wait = a_wait[w]; s_rdata = a_rdata[w]; s_err = a_err[w];
        miss = (a_addr[w] >> SLV_SHIFT) >= SLAVES;
        idx  = int'((a_addr[w] >> SLV_SHIFT) % SLAVES);
        tmo  = (s_wait >= TIMEOUT);
        ew = '0; ew[w] = 1'b1;
        esel = '0; if (!miss) esel[idx] = 1'b1;

        @(negedge HCLK);
        chk("idle_state", {busy, gnt, PSEL, PENABLE, done}, '0);
        @(negedge HCLK);
        chk("grant", {busy, gnt}, {1'b1, ew});
        if (miss) begin
            chk("miss_resp", {PSEL, PENABLE, done, rsp_err}, {{SLAVES{1'b0}}, 1'b0, ew, 1'b1});
        end else begin
            chk("setup", {PSEL, PENABLE, done}, {esel, 1'b0, {NREQ{1'b0}}});
            chk("setup_addr", {PWRITE, PADDR}, {a_write[w], a_addr[w]});
            chk("setup_wdata", PWDATA, a_wdata[w]);
        end
        if (rnd) begin
            // Late withdrawals: the granted one must still complete
            if ($urandom_range(0, 3) == 0) act[w] = 1'b0;
            for (int j = 0; j < NREQ; j++)
                if (j != w && $urandom_range(0, 7) == 0) act[j] = 1'b0;
            drive_reqs();
        end
        if (!miss) begin
            nacc = tmo ? TIMEOUT : s_wait + 1;
            for (int k = 0; k < nacc; k++) begin
                @(negedge HCLK);
                chk("access", {gnt, PSEL, PENABLE, done}, {ew, esel, 1'b1, {NREQ{1'b0}}});
            end
            @(negedge HCLK);
            chk("resp", {gnt, PSEL, PENABLE, done}, {ew, {SLAVES{1'b0}}, 1'b0, ew});
            chk("resp_err", rsp_err, tmo ? 1'b1 : s_err);
            if (!tmo) chk("resp_rdata", rsp_rdata, a_write[w] ? 32'd0 : s_rdata);
        end
        @(posedge HCLK); #1;
        ptr = (w + 1) % NREQ;
        if (rnd) begin
            if (act[w] && $urandom_range(0, 1) == 1) new_txn(w);
            else act[w] = 1'b0;
            refill();
            drive_reqs();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0, 0, 0, 0, 0);
        drive_reqs();
        repeat (2) @(negedge HCLK);
        chk("rst_ctl", {gnt, done, PSEL, PENABLE, PWRITE, rsp_err, busy}, '0);
        chk("rst_data", {PADDR, PWDATA}, '0);
        chk("rst_rdata", rsp_rdata, '0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        // Zero-wait write to slave 1
        set_req(0, 1, 32'h0000_1004, 1, 32'hDEAD_BEEF, 0, 32'h0BAD_F00D, 0);
        drive_reqs(); serve(0);
        // Both held, zero-wait reads: grants must alternate
        set_req(0, 1, 32'h0000_0010, 0, 0, 0, 32'hA0A0_0001, 0);
        set_req(1, 1, 32'h0000_2020, 0, 0, 0, 32'hB0B0_0002, 0);
        drive_reqs();
        repeat (4) serve(0);
        // Wait-stated read from slave 3
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        set_req(1, 1, 32'h0000_3000, 0, 0, 3, 32'h1234_5678, 0);
        drive_reqs(); serve(0);
        // Hung slave, then a normal transfer
        set_req(1, 1, 32'h0000_2000, 0, 0, 100, 32'h5555_AAAA, 0);
        drive_reqs(); serve(0);
        set_req(1, 1, 32'h0000_2004, 1, 32'h0F0F_0F0F, 1, 0, 0);
        drive_reqs(); serve(0);
        // Ready on the final allowed cycle beats the timeout
        set_req(1, 1, 32'h0000_1008, 0, 0, TIMEOUT - 1, 32'hCAFE_0001, 0);
        drive_reqs(); serve(0);
        // Decode miss, then slave error
        set_req(1, 0, 0, 0, 0, 0, 0, 0);
        set_req(0, 1, 32'h0001_0000, 0, 0, 0, 0, 0);
        drive_reqs(); serve(0);
        set_req(0, 1, 32'h0000_1100, 1, 32'h7777_0000, 0, 0, 1);
        drive_reqs(); serve(0);

        // Randomized traffic
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        drive_reqs();
        for (int e = 0; e < 300; e++) serve(1);

        // Drain, then reset in the middle of an access
        for (int i = 0; i < NREQ; i++) act[i] = 1'b0;
        drive_reqs();
        @(negedge HCLK); @(negedge HCLK);
        while (busy) @(negedge HCLK);
        @(posedge HCLK); #1;
        set_req(0, 1, 32'h0000_0100, 0, 0, 0, 32'h1, 0);
        drive_reqs(); serve(0);
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        set_req(1, 1, 32'h0000_0000, 0, 0, 100, 32'h2, 0);
        drive_reqs();
        @(negedge HCLK); @(negedge HCLK);
        chk("rst_pre_gnt", gnt, 2'b10);
        @(negedge HCLK);
        chk("rst_pre_access", {PSEL, PENABLE}, {4'b0001, 1'b1});
        #2 HRESETn = 1'b0;
        #1 chk("rst_mid", {gnt, PSEL, PENABLE, done, busy}, '0);
        act[1] = 1'b0; drive_reqs();
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        ptr = 0;
        repeat (3) begin
            @(negedge HCLK);
            chk("rst_no_done", {done, busy}, '0);
        end
        @(posedge HCLK); #1;
        set_req(0, 1, 32'h0000_0200, 0, 0, 0, 32'h3, 0);
        set_req(1, 1, 32'h0000_0300, 0, 0, 0, 32'h4, 0);
        drive_reqs(); serve(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
